seq_add_sub: RTL and testbench

- Multi-cycle, parametrised adder/subtractor.
- Adds or subtracts two SIZE-bit operands one CHUNK-bit slice per cycle, LSB slice first, with the carry held in a register between slices.
- Trades latency for area against the flat ripple adder.
- Used as the ALU arithmetic unit when SIZE is wide. Controller talks to it via a start/ready request and a one-cycle done pulse.

---
 rtl/seq_add_sub.sv | 128 ++++++++++++
 tb/tb_seq_add_sub.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_add_sub.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice per clock, LSB first, carry held between slices.
// Optional saturation on signed overflow when SEQ_ADD_SUB_SAT_EN is defined (adds the sat input).
module seq_add_sub #(
  parameter int SIZE  = 32,
  parameter int CHUNK = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_valid,
  output logic            start_ready,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic            sub,
  input  logic            ci,
`ifdef SEQ_ADD_SUB_SAT_EN
  input  logic            sat,
`endif
  output logic [SIZE-1:0] r,
  output logic            co,
  output logic            ovf,
  output logic            zero,
  output logic            busy,
  output logic            done,
  output logic [1:0]      dbg_state
);

  localparam int NCHUNK = SIZE / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [SIZE-1:0] a_q;
  logic [SIZE-1:0] b_q;
  logic [SIZE-1:0] sum_q;
  logic            carry;
  logic [CW-1:0]   cnt;
`ifdef SEQ_ADD_SUB_SAT_EN
  logic            sat_q;
`endif

  logic [CHUNK-1:0] a_sl;
  logic [CHUNK-1:0] b_sl;
  logic [CHUNK:0]   slice_sum;
  logic [SIZE-1:0]  sum_nxt;
  logic [SIZE-1:0]  r_nxt;
  logic             ovf_nxt;
  logic             last;

  // Handshake: a request is accepted on a rising edge where start_valid && start_ready;
  // start_ready is high in IDLE and DONE, low in RUN, and start_valid is ignored in RUN.
  assign start_ready = (state != RUN);
  assign busy        = (state == RUN);
  assign dbg_state   = state;
  assign last        = (cnt == CW'(NCHUNK - 1));

  always_comb begin
    a_sl      = a_q[cnt*CHUNK +: CHUNK];
    b_sl      = b_q[cnt*CHUNK +: CHUNK];
    slice_sum = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, carry};
    sum_nxt   = sum_q;
    sum_nxt[cnt*CHUNK +: CHUNK] = slice_sum[CHUNK-1:0];
    // b_q already holds the inverted operand for subtraction
    ovf_nxt   = (a_q[SIZE-1] == b_q[SIZE-1]) && (sum_nxt[SIZE-1] != a_q[SIZE-1]);
    r_nxt     = sum_nxt;
`ifdef SEQ_ADD_SUB_SAT_EN
    if (sat_q && ovf_nxt)
      r_nxt = a_q[SIZE-1] ? {1'b1, {(SIZE-1){1'b0}}} : {1'b0, {(SIZE-1){1'b1}}};
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      sum_q <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      r     <= '0;
      co    <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b0;
      done  <= 1'b0;
`ifdef SEQ_ADD_SUB_SAT_EN
      sat_q <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start_valid) begin
            a_q   <= a;
            b_q   <= sub ? ~b : b;
            carry <= sub ? 1'b1 : ci;
            cnt   <= '0;
`ifdef SEQ_ADD_SUB_SAT_EN
            sat_q <= sat;
`endif
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          sum_q <= sum_nxt;
          carry <= slice_sum[CHUNK];
          if (last) begin
            r     <= r_nxt;
            co    <= slice_sum[CHUNK];
            ovf   <= ovf_nxt;
            zero  <= (r_nxt == '0);
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_add_sub.sv
// Bench for seq_add_sub: reference model feeds an expected queue, a negedge monitor checks every done.
module tb_seq_add_sub;
  localparam int SIZE   = 32;
  localparam int CHUNK  = 8;
  localparam int NCHUNK = SIZE / CHUNK;
  localparam int W      = SIZE + 3;

  logic            clk;
  logic            rst_n;
  logic            start_valid;
  logic            start_ready;
  logic [SIZE-1:0] a;
  logic [SIZE-1:0] b;
  logic            sub;
  logic            ci;
  logic            sat;
  logic [SIZE-1:0] r;
  logic            co;
  logic            ovf;
  logic            zero;
  logic            busy;
  logic            done;
  logic [1:0]      dbg_state;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_out;
  logic         prev_done;
  int           n_vec;
  int           n_err;
  int           cyc;
  int           acc_cyc;

  seq_add_sub #(.SIZE(SIZE), .CHUNK(CHUNK)) dut (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
    .a(a), .b(b), .sub(sub), .ci(ci),
`ifdef SEQ_ADD_SUB_SAT_EN
    .sat(sat),
`endif
    .r(r), .co(co), .ovf(ovf), .zero(zero), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [SIZE-1:0] ta, input logic [SIZE-1:0] tb,
                                         input logic tsub, input logic tci, input logic tsat);
    logic [SIZE-1:0] bb;
    logic [SIZE:0]   full;
    logic [SIZE-1:0] s;
    logic            o;
    bb   = tsub ? ~tb : tb;
    full = {1'b0, ta} + {1'b0, bb} + {{SIZE{1'b0}}, (tsub ? 1'b1 : tci)};
    s    = full[SIZE-1:0];
    o    = (ta[SIZE-1] == bb[SIZE-1]) && (s[SIZE-1] != ta[SIZE-1]);
`ifdef SEQ_ADD_SUB_SAT_EN
    if (tsat && o) s = ta[SIZE-1] ? {1'b1, {(SIZE-1){1'b0}}} : {1'b0, {(SIZE-1){1'b1}}};
`else
    if (tsat) s = s;
`endif
    return {s, full[SIZE], o, (s == '0)};
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) check("hold_outputs", {r, co, ovf, zero}, last_out);
      if (done) begin
        check("done_twice", prev_done, 1'b0);
        check("latency", cyc - acc_cyc, NCHUNK);
        if (exp_q.size() == 0) begin
          check("spurious_done", done, 1'b0);
        end else begin
          check("result", {r, co, ovf, zero}, exp_q.pop_front());
        end
        last_out = {r, co, ovf, zero};
      end
      prev_done = done;
    end else begin
      prev_done = 1'b0;
      last_out  = '0;
    end
  end

  // driver tasks: called just after a negedge
  task automatic drive_op(input logic [SIZE-1:0] ta, input logic [SIZE-1:0] tb,
                          input logic tsub, input logic tci, input logic tsat);
    start_valid = 1'b1;
    a = ta; b = tb; sub = tsub; ci = tci; sat = tsat;
    exp_q.push_back(model(ta, tb, tsub, tci, tsat));
    @(posedge clk);
    #1;
    acc_cyc     = cyc;
    start_valid = 1'b0;
    a   = $urandom;
    b   = $urandom;
    sub = 1'($urandom_range(0, 1));
    ci  = 1'($urandom_range(0, 1));
    sat = 1'($urandom_range(0, 1));
  endtask

  task automatic run_op(input logic [SIZE-1:0] ta, input logic [SIZE-1:0] tb,
                        input logic tsub, input logic tci, input logic tsat);
    int guard;
    int nbusy;
    guard = 0;
    while (!start_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("ready_before_op", start_ready, 1'b1);
    drive_op(ta, tb, tsub, tci, tsat);
    nbusy = 0;
    guard = 0;
    @(negedge clk);
    while (!done && guard < 100) begin
      if (busy) nbusy++;
      guard++;
      @(negedge clk);
    end
    check("done_timeout", done, 1'b1);
    check("busy_cycles", nbusy, NCHUNK);
  endtask

  initial begin
    n_vec = 0; n_err = 0; acc_cyc = 0;
    prev_done = 1'b0; last_out = '0;
    rst_n = 1'b0; start_valid = 1'b0;
    a = '0; b = '0; sub = 1'b0; ci = 1'b0; sat = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_r", r, 0);
    check("rst_flags", {co, ovf, zero, busy, done}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", start_ready, 1'b1);
    check("rst_state", dbg_state, 2'd0);

    run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    check("add_r", r, 32'h0000_0100);
    check("add_flags", {co, ovf, zero}, 3'b000);
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);
    check("idle_after_done", dbg_state, 2'd0);

    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    check("wrap_r", r, 0);
    check("wrap_flags", {co, ovf, zero}, 3'b101);
    @(negedge clk);
    run_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 1'b0);
    check("wrap_ci_r", r, 0);
    check("wrap_ci_flags", {co, ovf, zero}, 3'b101);
    @(negedge clk);

    run_op(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 1'b0);
    check("subovf_r", r, 32'h7FFF_FFFF);
    check("subovf_flags", {co, ovf}, 2'b11);
    @(negedge clk);
    run_op(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 1'b0);
    check("borrow_r", r, 32'hFFFF_FFFE);
    check("borrow_flags", {co, ovf}, 2'b00);

    // back-to-back: accept in the DONE cycle
    check("b2b_in_done", dbg_state, 2'd2);
    run_op(32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0, 1'b0);
    check("b2b_r", r, 32'h0000_0007);
    run_op(32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    check("chunk_carry_r", r, 32'h0100_0000);
    @(negedge clk);

`ifdef SEQ_ADD_SUB_SAT_EN
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
    check("sat_pos_r", r, 32'h7FFF_FFFF);
    check("sat_pos_ovf", ovf, 1'b1);
    @(negedge clk);
    run_op(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 1'b1);
    check("sat_neg_r", r, 32'h8000_0000);
    @(negedge clk);
`endif

    // reset in the middle of an operation: no done, outputs cleared
    start_valid = 1'b1; a = 32'h1; b = 32'h1; sub = 1'b0; ci = 1'b0; sat = 1'b0;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_r", r, 0);
    check("midrst_flags", {co, ovf, zero, busy, done}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("midrst_no_done", {done, busy, start_ready}, 3'b001);
    end

    // random traffic with optional idle gaps
    for (int i = 0; i < 24; i++) begin
      logic [SIZE-1:0] ra;
      logic [SIZE-1:0] rb;
      ra = (i % 4 == 0) ? 32'h7FFF_FFFF : $urandom;
      rb = (i % 5 == 0) ? 32'hFFFF_FFFF : $urandom;
      run_op(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
